// File: rtl/lfsrentsrc_ctrl.sv
// Sequencer for the ring-LFSR entropy source: source reset, warm-up, decimated capture,
// repetition-count health test and packing of samples into valid/ready words.
module lfsrentsrc_ctrl #(
   parameter int RNG_WIDTH     = 4,
   parameter int OUT_WIDTH     = 32,
   parameter int WARMUP_CYCLES = 16,
   parameter int DECIM         = 1,
   parameter int REP_LIMIT     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_start,
   input  logic [RNG_WIDTH-1:0] i_src_rnd,
   output logic                 o_src_reset,
   output logic                 o_src_en,
   output logic [OUT_WIDTH-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   input  logic                 i_clear_alarm,
   output logic                 o_alarm
);

   localparam int N     = OUT_WIDTH / RNG_WIDTH;
   localparam int TMR_W = $clog2(WARMUP_CYCLES + 2);
   localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int SMP_W = (N > 1) ? $clog2(N) : 1;
   localparam int REP_W = $clog2(REP_LIMIT + 1);

   localparam logic [TMR_W-1:0] WARM_LAST = TMR_W'(WARMUP_CYCLES - 1);
   localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(DECIM - 1);
   localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(N - 1);
   localparam logic [REP_W-1:0] REP_MAX   = REP_W'(REP_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SRST,
      S_WARMUP,
      S_COLLECT,
      S_HOLD,
      S_ALARM
   } state_t;

   state_t               state_q;
   logic [TMR_W-1:0]     tmr_q;
   logic [DEC_W-1:0]     dec_q;
   logic [SMP_W-1:0]     smp_q;
   logic [REP_W-1:0]     rep_q;
   logic [RNG_WIDTH-1:0] prev_q;
   logic [OUT_WIDTH-1:0] acc_q;
   logic [OUT_WIDTH-1:0] data_q;
   logic                 src_reset_q;
   logic                 src_en_q;
   logic                 valid_q;
   logic                 alarm_q;

   logic                 cap_d;
   logic [REP_W-1:0]     rep_d;
   logic [OUT_WIDTH-1:0] acc_d;

   assign cap_d = (state_q == S_COLLECT) && i_start && (dec_q == DEC_LAST);

   // rep_q == 0 marks "no previous sample in this run", so prev_q needs no reset
   always_comb begin
      rep_d = REP_W'(1);
      if ((i_src_rnd == prev_q) && (rep_q != '0)) begin
         rep_d = (rep_q == REP_MAX) ? rep_q : rep_q + REP_W'(1);
      end
   end

   generate
      if (N > 1) begin : g_shift
         assign acc_d = {acc_q[OUT_WIDTH-RNG_WIDTH-1:0], i_src_rnd};
      end else begin : g_single
         assign acc_d = i_src_rnd;
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (cap_d) begin
         acc_q  <= acc_d;
         prev_q <= i_src_rnd;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         dec_q       <= '0;
         smp_q       <= '0;
         rep_q       <= '0;
         data_q      <= '0;
         src_reset_q <= 1'b0;
         src_en_q    <= 1'b0;
         valid_q     <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  state_q     <= S_SRST;
                  src_reset_q <= 1'b1;
                  tmr_q       <= '0;
               end
            end
            S_SRST: begin
               if (!i_start) begin
                  state_q     <= S_IDLE;
                  src_reset_q <= 1'b0;
               end else if (tmr_q == TMR_W'(1)) begin
                  state_q     <= S_WARMUP;
                  src_reset_q <= 1'b0;
                  src_en_q    <= 1'b1;
                  tmr_q       <= '0;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            S_WARMUP: begin
               if (!i_start) begin
                  state_q  <= S_IDLE;
                  src_en_q <= 1'b0;
               end else if (tmr_q == WARM_LAST) begin
                  state_q <= S_COLLECT;
                  dec_q   <= '0;
                  smp_q   <= '0;
                  rep_q   <= '0;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            S_COLLECT: begin
               if (!i_start) begin
                  state_q  <= S_IDLE;
                  src_en_q <= 1'b0;
               end else begin
                  dec_q <= (dec_q == DEC_LAST) ? '0 : dec_q + DEC_W'(1);
                  if (cap_d) begin
                     rep_q <= rep_d;
                     // a failing health test wins over completing the word
                     if (rep_d == REP_MAX) begin
                        state_q  <= S_ALARM;
                        alarm_q  <= 1'b1;
                        src_en_q <= 1'b0;
                     end else if (smp_q == SMP_LAST) begin
                        state_q <= S_HOLD;
                        data_q  <= acc_d;
                        valid_q <= 1'b1;
                     end else begin
                        smp_q <= smp_q + SMP_W'(1);
                     end
                  end
               end
            end
            S_HOLD: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  if (i_start) begin
                     state_q <= S_COLLECT;
                     dec_q   <= '0;
                     smp_q   <= '0;
                  end else begin
                     state_q  <= S_IDLE;
                     src_en_q <= 1'b0;
                  end
               end
            end
            S_ALARM: begin
               if (i_clear_alarm) begin
                  state_q <= S_IDLE;
                  alarm_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               src_reset_q <= 1'b0;
               src_en_q    <= 1'b0;
               valid_q     <= 1'b0;
               alarm_q     <= 1'b0;
            end
         endcase
      end
   end

   assign o_src_reset = src_reset_q;
   assign o_src_en    = src_en_q;
   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_alarm     = alarm_q;

endmodule

// File: tb/tb_lfsrentsrc_ctrl.sv
// Bench for lfsrentsrc_ctrl: two instances (DECIM=1 16-bit words, DECIM=3 32-bit words),
// expected words derived from the source history at the capture edges given by the timing rules.
module tb_lfsrentsrc_ctrl;

   localparam int RW = 4;
   localparam int WU = 4;
   localparam int D0 = 1;
   localparam int N0 = 4;
   localparam int D1 = 3;
   localparam int N1 = 8;

   localparam int M_RAND  = 0;
   localparam int M_STUCK = 1;
   localparam int M_CNT   = 2;
   localparam int M_CYC   = 3;

   typedef struct {
      logic [31:0] data;
      int          rise;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  start;
   logic [3:0]  src;
   logic        ready;
   logic        clr;
   logic        srst0, en0, valid0, alarm0;
   logic        srst1, en1, valid1, alarm1;
   logic [15:0] data0;
   logic [31:0] data1;

   int          cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          src_mode = M_RAND;
   int          cnt_val = 0;
   int          cnt_base = 0;
   logic [3:0]  hist [0:16383];
   exp_t        q0[$];
   exp_t        q1[$];

   lfsrentsrc_ctrl #(.RNG_WIDTH(RW), .OUT_WIDTH(16), .WARMUP_CYCLES(WU), .DECIM(D0), .REP_LIMIT(8)) u_dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start[0]), .i_src_rnd(src),
      .o_src_reset(srst0), .o_src_en(en0), .o_data(data0), .o_valid(valid0),
      .i_ready(ready), .i_clear_alarm(clr), .o_alarm(alarm0));

   lfsrentsrc_ctrl #(.RNG_WIDTH(RW), .OUT_WIDTH(32), .WARMUP_CYCLES(WU), .DECIM(D1), .REP_LIMIT(8)) u_dut1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start[1]), .i_src_rnd(src),
      .o_src_reset(srst1), .o_src_en(en1), .o_data(data1), .o_valid(valid1),
      .i_ready(ready), .i_clear_alarm(clr), .o_alarm(alarm1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic srst_of(input int i);
      return (i == 0) ? srst0 : srst1;
   endfunction
   function automatic logic en_of(input int i);
      return (i == 0) ? en0 : en1;
   endfunction
   function automatic logic valid_of(input int i);
      return (i == 0) ? valid0 : valid1;
   endfunction
   function automatic logic alarm_of(input int i);
      return (i == 0) ? alarm0 : alarm1;
   endfunction
   function automatic logic [31:0] data_of(input int i);
      return (i == 0) ? {16'h0, data0} : data1;
   endfunction

   // Advance to the next falling edge and present the source value for the following rising edge.
   task automatic tick();
      logic [3:0] nv;
      @(negedge clk);
      case (src_mode)
         M_STUCK: nv = 4'h5;
         M_CNT: begin
            if (cyc >= cnt_base && !valid0) cnt_val++;
            nv = cnt_val[3:0];
         end
         M_CYC: nv = 4'(cyc + 1);
         default: begin
            nv = 4'($urandom_range(0, 15));
            if (nv == src) nv = nv + 4'd1;
         end
      endcase
      src = nv;
      hist[cyc + 1] = nv;
   endtask

   task automatic wait_cyc(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 5000) begin
         tick();
         guard++;
      end
      if (cyc < c) check("wait bound", 32'(cyc), 32'(c));
   endtask

   task automatic start_run(input int inst, output int s);
      int t0, nrst;
      t0 = cyc + 1;
      start[inst] = 1'b1;
      nrst = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (srst_of(inst)) nrst++;
      end
      check("src_reset high cycles", 32'(nrst), 32'd2);
      check("src_en in warmup", 32'(en_of(inst)), 32'd1);
      s = t0 + 2 + WU;
   endtask

   task automatic word(input int inst, input int s, input int bp, input bit keep,
                       input bit use_fixed, input logic [31:0] fixed, output int a);
      int d, n, r;
      exp_t e;
      d = (inst == 0) ? D0 : D1;
      n = (inst == 0) ? N0 : N1;
      r = s + n * d;
      wait_cyc(r - 1);
      e.data = '0;
      for (int k = 1; k <= n; k++) e.data = (e.data << RW) | 32'(hist[s + k * d]);
      if (use_fixed) e.data = fixed;
      e.rise = r;
      if (inst == 0) q0.push_back(e);
      else q1.push_back(e);
      if (bp > 0) ready = 1'b0;
      if (!keep) begin
         wait_cyc(r);
         start[inst] = 1'b0;
      end
      wait_cyc(r + bp);
      check("src_en during HOLD", 32'(en_of(inst)), 32'd1);
      check("valid during HOLD", 32'(valid_of(inst)), 32'd1);
      ready = 1'b1;
      a = r + bp + 1;
      wait_cyc(a);
      if (!keep) begin
         check("src_en after stop in HOLD", 32'(en_of(inst)), 32'd0);
         check("valid after accept", 32'(valid_of(inst)), 32'd0);
      end
   endtask

   task automatic clear_alarm(input int inst);
      repeat (3) tick();
      check("alarm sticky with start high", 32'(alarm_of(inst)), 32'd1);
      check("no restart from ALARM", 32'(srst_of(inst)), 32'd0);
      start[inst] = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("alarm cleared", 32'(alarm_of(inst)), 32'd0);
      check("src_en after clear", 32'(en_of(inst)), 32'd0);
      tick();
   endtask

   task automatic check_all_zero(input int inst, input string name);
      check({name, " src_reset"}, 32'(srst_of(inst)), 32'd0);
      check({name, " src_en"}, 32'(en_of(inst)), 32'd0);
      check({name, " valid"}, 32'(valid_of(inst)), 32'd0);
      check({name, " alarm"}, 32'(alarm_of(inst)), 32'd0);
      check({name, " data"}, data_of(inst), 32'd0);
   endtask

   // Monitor: pops an expected word on each rising o_valid, checks hold stability.
   logic        pv0 = 1'b0, pv1 = 1'b0;
   logic [31:0] pd0 = '0, pd1 = '0;
   exp_t        me0, me1;
   always begin
      @(posedge clk);
      #1;
      if (valid0) begin
         if (!pv0) begin
            if (q0.size() == 0) check("inst0 valid without expected word", 32'(valid0), 32'd0);
            else begin
               me0 = q0.pop_front();
               check("inst0 word", {16'h0, data0}, me0.data);
               check("inst0 valid rise cycle", 32'(cyc), 32'(me0.rise));
            end
         end else check("inst0 data stable", {16'h0, data0}, pd0);
      end
      if (valid1) begin
         if (!pv1) begin
            if (q1.size() == 0) check("inst1 valid without expected word", 32'(valid1), 32'd0);
            else begin
               me1 = q1.pop_front();
               check("inst1 word", data1, me1.data);
               check("inst1 valid rise cycle", 32'(cyc), 32'(me1.rise));
            end
         end else check("inst1 data stable", data1, pd1);
      end
      pv0 = valid0;
      pd0 = {16'h0, data0};
      pv1 = valid1;
      pd1 = data1;
   end

   initial begin
      int s, a, a2, r;
      exp_t e;
      rst_n = 1'b0;
      start = 2'b00;
      ready = 1'b1;
      clr = 1'b0;
      src = 4'h0;
      repeat (3) tick();
      check_all_zero(0, "reset inst0");
      check_all_zero(1, "reset inst1");
      rst_n = 1'b1;
      repeat (2) tick();

      // Basic packing with a counting source that pauses while a word is held
      src_mode = M_CNT;
      cnt_val = 0;
      cnt_base = cyc + 1 + 2 + WU;
      start_run(0, s);
      word(0, s, 0, 1'b1, 1'b1, 32'h1234, a);
      word(0, a, 0, 1'b0, 1'b1, 32'h5678, a2);
      repeat (3) tick();

      // Backpressure then stop in HOLD
      src_mode = M_RAND;
      start_run(0, s);
      word(0, s, 10, 1'b1, 1'b0, 32'h0, a);
      word(0, a, 0, 1'b0, 1'b0, 32'h0, a2);
      repeat (2) tick();

      // Stop mid-COLLECT
      start_run(0, s);
      wait_cyc(s + 2);
      start[0] = 1'b0;
      tick();
      check("src_en after stop in COLLECT", 32'(en0), 32'd0);
      repeat (6) tick();
      check("valid after stop in COLLECT", 32'(valid0), 32'd0);

      // Stuck source: first word delivered, repetition count carries across HOLD
      src_mode = M_STUCK;
      start_run(0, s);
      word(0, s, 0, 1'b1, 1'b1, 32'h5555, a);
      wait_cyc(a + 3);
      check("inst0 alarm before 8th capture", 32'(alarm0), 32'd0);
      tick();
      check("inst0 alarm at 8th capture", 32'(alarm0), 32'd1);
      check("inst0 src_en in ALARM", 32'(en0), 32'd0);
      check("inst0 valid in ALARM", 32'(valid0), 32'd0);
      clear_alarm(0);

      // Decimation with a cycle-counter source
      src_mode = M_CYC;
      start_run(1, s);
      word(1, s, 0, 1'b1, 1'b0, 32'h0, a);
      word(1, a, 2, 1'b0, 1'b0, 32'h0, a2);
      repeat (2) tick();

      // Stuck source on the wide instance: alarm preempts word completion
      src_mode = M_STUCK;
      start_run(1, s);
      wait_cyc(s + 23);
      check("inst1 alarm before 8th capture", 32'(alarm1), 32'd0);
      check("inst1 src_en while collecting", 32'(en1), 32'd1);
      tick();
      check("inst1 alarm at 8th capture", 32'(alarm1), 32'd1);
      check("inst1 src_en in ALARM", 32'(en1), 32'd0);
      check("inst1 valid in ALARM", 32'(valid1), 32'd0);
      clear_alarm(1);
      src_mode = M_RAND;
      start_run(1, s);
      word(1, s, 0, 1'b0, 1'b0, 32'h0, a);
      repeat (2) tick();

      // Asynchronous reset mid-WARMUP
      start_run(1, s);
      #2 rst_n = 1'b0;
      #1 check_all_zero(1, "async reset in WARMUP");
      start[1] = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Asynchronous reset while a word is held
      start_run(0, s);
      r = s + N0 * D0;
      wait_cyc(r - 1);
      e.data = '0;
      for (int k = 1; k <= N0; k++) e.data = (e.data << RW) | 32'(hist[s + k * D0]);
      e.rise = r;
      q0.push_back(e);
      ready = 1'b0;
      wait_cyc(r + 2);
      #2 rst_n = 1'b0;
      #1 check_all_zero(0, "async reset in HOLD");
      start[0] = 1'b0;
      tick();
      rst_n = 1'b1;
      ready = 1'b1;
      tick();

      // Randomised runs on both instances
      for (int it = 0; it < 8; it++) begin
         int inst, nw, rs, ra, bp;
         src_mode = M_RAND;
         inst = int'($urandom_range(0, 1));
         nw = int'($urandom_range(1, 3));
         start_run(inst, rs);
         for (int w = 0; w < nw; w++) begin
            bp = int'($urandom_range(0, 4));
            word(inst, rs, bp, (w != nw - 1), 1'b0, 32'h0, ra);
            rs = ra;
         end
         repeat (int'($urandom_range(1, 3))) tick();
      end

      repeat (5) tick();
      check("inst0 words outstanding", 32'(q0.size()), 32'd0);
      check("inst1 words outstanding", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
